// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock key front end: key indices,
// per-key debounce FSM encoding and a small parameter helper.
package clock_pkg;

  localparam int unsigned KEY_DATE   = 32'd0;
  localparam int unsigned KEY_MODE   = 32'd1;
  localparam int unsigned KEY_SHIFT  = 32'd2;
  localparam int unsigned KEY_INC    = 32'd3;
  localparam int unsigned KEY_DEC    = 32'd4;
  localparam int unsigned KEY_SW_RUN = 32'd5;
  localparam int unsigned KEY_SW_CLR = 32'd6;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESS_CHK = 2'd1,
    ST_HELD      = 2'd2,
    ST_REL_CHK   = 2'd3
  } key_fsm_e;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchroniser, debounce FSM, debounce and auto-repeat
// counters. All outputs come straight from flops.
module key_channel
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC    = 32'd1_000_000,
  parameter int unsigned REPEAT_DLY_CYC  = 32'd25_000_000,
  parameter int unsigned REPEAT_RATE_CYC = 32'd5_000_000,
  parameter bit          REPEAT_EN       = 1'b0,
  parameter int unsigned CNT_W           = 32'd25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_press,
  output logic key_release,
  output logic key_state
);

  // Counters compare their pre-increment value against "target minus one",
  // so a target equal to a power of two still fits in CNT_W bits.
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] DB_LAST   =
    CNT_W'((DEBOUNCE_CYC >= 32'd2) ? (DEBOUNCE_CYC - 32'd2) : 32'd0);
  localparam logic [CNT_W-1:0] DLY_LAST  =
    CNT_W'((REPEAT_DLY_CYC >= 32'd1) ? (REPEAT_DLY_CYC - 32'd1) : 32'd0);
  localparam logic [CNT_W-1:0] RATE_LAST =
    CNT_W'((REPEAT_RATE_CYC >= 32'd1) ? (REPEAT_RATE_CYC - 32'd1) : 32'd0);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  key_fsm_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic             rep_done_q, rep_done_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [CNT_W-1:0] rcnt_inc_s;
  logic [CNT_W-1:0] rep_last_s;

  // Next-state, counter and pulse logic for the debounce/repeat FSM.
  always_comb begin
    sync1_d    = key_n;
    sync2_d    = sync1_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    rcnt_d     = rcnt_q;
    rep_done_d = rep_done_q;
    level_d    = level_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    cnt_inc_s  = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
    rcnt_inc_s = (rcnt_q == CNT_MAX) ? rcnt_q : (rcnt_q + CNT_ONE);
    rep_last_s = rep_done_q ? RATE_LAST : DLY_LAST;
    case (state_q)
      ST_IDLE: begin
        if (!sync2_q) begin
          state_d = ST_PRESS_CHK;
          cnt_d   = '0;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_PRESS_CHK: begin
        if (sync2_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= DB_LAST) begin
          state_d    = ST_HELD;
          cnt_d      = '0;
          rcnt_d     = '0;
          rep_done_d = 1'b0;
          level_d    = 1'b1;
          press_d    = 1'b1;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_HELD: begin
        if (sync2_q) begin
          state_d = ST_REL_CHK;
          cnt_d   = '0;
        end else if (REPEAT_EN && (rcnt_q >= rep_last_s)) begin
          rcnt_d     = '0;
          rep_done_d = 1'b1;
          press_d    = 1'b1;
        end else if (REPEAT_EN) begin
          rcnt_d = rcnt_inc_s;
        end else begin
          rcnt_d = rcnt_q;
        end
      end
      ST_REL_CHK: begin
        // A bounce back to 0 resumes HELD; the repeat counter keeps its value.
        if (!sync2_q) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q >= DB_LAST) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        cnt_d      = '0;
        rcnt_d     = '0;
        rep_done_d = 1'b0;
        level_d    = 1'b0;
      end
    endcase
  end

  // State, counter, synchroniser and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rcnt_q     <= '0;
      rep_done_q <= 1'b0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rcnt_q     <= rcnt_d;
      rep_done_q <= rep_done_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
    end
  end

  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_state   = level_q;

endmodule

// File: rtl/key_debounce_repeat.sv
// Key conditioning front end: one independent debounce channel per raw
// active-low button, with auto-repeat on the keys selected by REPEAT_MASK.
module key_debounce_repeat
  import clock_pkg::*;
#(
  parameter int unsigned         NUM_KEYS        = 32'd7,
  parameter int unsigned         DEBOUNCE_CYC    = 32'd1_000_000,
  parameter int unsigned         REPEAT_DLY_CYC  = 32'd25_000_000,
  parameter int unsigned         REPEAT_RATE_CYC = 32'd5_000_000,
  parameter logic [NUM_KEYS-1:0] REPEAT_MASK     = 7'b0011000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_state
);

  localparam int unsigned CNT_RAW =
    $clog2(max3(DEBOUNCE_CYC, REPEAT_DLY_CYC, REPEAT_RATE_CYC));
  localparam int unsigned CNT_W = (CNT_RAW < 32'd1) ? 32'd1 : CNT_RAW;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_channel #(
      .DEBOUNCE_CYC   (DEBOUNCE_CYC),
      .REPEAT_DLY_CYC (REPEAT_DLY_CYC),
      .REPEAT_RATE_CYC(REPEAT_RATE_CYC),
      .REPEAT_EN      (REPEAT_MASK[i]),
      .CNT_W          (CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_n      (key_in[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_state  (key_state[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_repeat.sv
// Self-checking bench for key_debounce_repeat: directed scenarios plus random
// key activity compared cycle by cycle against a run-length reference model.
module tb_key_debounce_repeat;

  localparam int NK   = 7;
  localparam int DB   = 8;
  localparam int DLY  = 40;
  localparam int RATE = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_press, key_release, key_state;

  int total = 0;
  int bad   = 0;

  // Reference model: raw input delayed two edges, run lengths of equal samples.
  logic [NK-1:0] rmask = 7'b0011000;
  logic [NK-1:0] d1_m, d2_m, prev_m, lvl_m, done_m, exp_p, exp_r;
  int run0[NK];
  int run1[NK];
  int hold_m[NK];

  key_debounce_repeat #(
    .NUM_KEYS(NK), .DEBOUNCE_CYC(DB), .REPEAT_DLY_CYC(DLY),
    .REPEAT_RATE_CYC(RATE), .REPEAT_MASK(7'b0011000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .key_press(key_press), .key_release(key_release), .key_state(key_state)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    d1_m = '1; d2_m = '1; prev_m = '1; lvl_m = '0; done_m = '0;
    exp_p = '0; exp_r = '0;
    for (int i = 0; i < NK; i++) begin
      run0[i] = 0; run1[i] = 0; hold_m[i] = 0;
    end
  endtask

  // Advance one clock: update the model at the rising edge, return at the falling edge.
  task automatic tick();
    logic [NK-1:0] s;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      s = d2_m; d2_m = d1_m; d1_m = key_in;
      exp_p = '0; exp_r = '0;
      for (int i = 0; i < NK; i++) begin
        if (s[i]) begin run1[i]++; run0[i] = 0; end
        else      begin run0[i]++; run1[i] = 0; end
        if (!lvl_m[i]) begin
          if (run0[i] >= DB) begin
            lvl_m[i] = 1'b1; exp_p[i] = 1'b1; hold_m[i] = 0; done_m[i] = 1'b0;
          end
        end else if (run1[i] >= DB) begin
          lvl_m[i] = 1'b0; exp_r[i] = 1'b1;
        end else if (rmask[i] && !s[i] && !prev_m[i]) begin
          hold_m[i]++;
          if (hold_m[i] >= (done_m[i] ? RATE : DLY)) begin
            exp_p[i] = 1'b1; hold_m[i] = 0; done_m[i] = 1'b1;
          end
        end
      end
      prev_m = s;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) tick();
    total++;
    if ({key_press, key_release, key_state} !== {3*NK{1'b0}}) begin
      bad++;
      $display("FAIL reset_outputs: got p=%b r=%b s=%b want all 0", key_press, key_release, key_state);
    end
    rst_n = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      tick();
      total++;
      if ({key_press, key_release, key_state} !== {exp_p, exp_r, lvl_m}) begin
        bad++;
        $display("FAIL reset_idle: cyc %0d got p=%b r=%b s=%b want p=%b r=%b s=%b",
                 j, key_press, key_release, key_state, exp_p, exp_r, lvl_m);
      end
    end
  endtask

  task automatic test_clean_press();
    int n_p = 0, at_p = -1, n_r = 0, at_r = -1;
    key_in[0] = 1'b0;
    for (int j = 1; j <= 30; j++) begin
      if (j == 16) key_in[0] = 1'b1;
      tick();
      if (key_press[0])   begin n_p++; at_p = j; end
      if (key_release[0]) begin n_r++; at_r = j - 15; end
      total++;
      if ({key_press, key_release, key_state} !== {exp_p, exp_r, lvl_m}) begin
        bad++;
        $display("FAIL clean_model: cyc %0d got p=%b r=%b s=%b want p=%b r=%b s=%b",
                 j, key_press, key_release, key_state, exp_p, exp_r, lvl_m);
      end
    end
    total++;
    if (n_p !== 1 || at_p !== 10) begin
      bad++; $display("FAIL clean_press: got %0d pulses at %0d want 1 at 10", n_p, at_p);
    end
    total++;
    if (n_r !== 1 || at_r !== 10) begin
      bad++; $display("FAIL clean_release: got %0d pulses at +%0d want 1 at +10", n_r, at_r);
    end
  endtask

  task automatic test_glitch();
    int n_out = 0;
    key_in[2] = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      if (j == 6) key_in[2] = 1'b1;
      tick();
      if (key_press[2] || key_release[2] || key_state[2]) n_out++;
    end
    total++;
    if (n_out !== 0) begin
      bad++; $display("FAIL glitch: got %0d active cycles want 0", n_out);
    end
  endtask

  task automatic test_bounce();
    int n_p = 0, at_p = -1;
    for (int t = 0; t < 4; t++) begin
      key_in[1] = t[0];
      repeat (3) begin
        tick();
        if (key_press[1]) n_p++;
      end
    end
    key_in[1] = 1'b0;
    for (int j = 1; j <= 15; j++) begin
      tick();
      if (key_press[1]) begin n_p++; at_p = j; end
    end
    total++;
    if (n_p !== 1 || at_p !== 10) begin
      bad++; $display("FAIL bounce: got %0d pulses at %0d want 1 at 10", n_p, at_p);
    end
    key_in[1] = 1'b1;
    repeat (12) tick();
  endtask

  task automatic test_auto_repeat();
    int got3[$];
    int want3[6] = '{10, 50, 60, 70, 80, 90};
    int n5 = 0, at5 = -1;
    key_in[3] = 1'b0; key_in[5] = 1'b0;
    for (int j = 1; j <= 120; j++) begin
      if (j == 96) begin key_in[3] = 1'b1; key_in[5] = 1'b1; end
      tick();
      if (key_press[3]) got3.push_back(j);
      if (key_press[5]) begin n5++; at5 = j; end
      total++;
      if ({key_press, key_release, key_state} !== {exp_p, exp_r, lvl_m}) begin
        bad++;
        $display("FAIL repeat_model: cyc %0d got p=%b r=%b s=%b want p=%b r=%b s=%b",
                 j, key_press, key_release, key_state, exp_p, exp_r, lvl_m);
      end
    end
    total++;
    if (got3.size() !== 6) begin
      bad++; $display("FAIL repeat_count: got %0d pulses want 6", got3.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        total++;
        if (got3[k] !== want3[k]) begin
          bad++; $display("FAIL repeat_time: pulse %0d got %0d want %0d", k, got3[k], want3[k]);
        end
      end
    end
    total++;
    if (n5 !== 1 || at5 !== 10) begin
      bad++; $display("FAIL no_repeat_key5: got %0d pulses at %0d want 1 at 10", n5, at5);
    end
  endtask

  task automatic test_simultaneous();
    int both = 0, single = 0;
    key_in[3] = 1'b0; key_in[4] = 1'b0;
    for (int j = 1; j <= 35; j++) begin
      if (j == 21) begin key_in[3] = 1'b1; key_in[4] = 1'b1; end
      tick();
      if (key_press[3] && key_press[4] && j == 10) both++;
      else if (key_press[3] || key_press[4]) single++;
    end
    total++;
    if (both !== 1 || single !== 0) begin
      bad++; $display("FAIL simultaneous: got joint=%0d other=%0d want joint=1 other=0", both, single);
    end
  endtask

  task automatic test_reset_mid_hold();
    int n_p = 0, at_p = -1;
    key_in[6] = 1'b0;
    repeat (15) tick();
    total++;
    if (key_state[6] !== 1'b1) begin
      bad++; $display("FAIL hold_before_reset: got state %b want 1", key_state[6]);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({key_press, key_release, key_state} !== {3*NK{1'b0}}) begin
      bad++;
      $display("FAIL async_reset: got p=%b r=%b s=%b want all 0", key_press, key_release, key_state);
    end
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    for (int j = 1; j <= 15; j++) begin
      tick();
      if (key_press[6]) begin n_p++; at_p = j; end
    end
    total++;
    if (n_p !== 1 || at_p !== 10) begin
      bad++; $display("FAIL press_after_reset: got %0d pulses at %0d want 1 at 10", n_p, at_p);
    end
    key_in[6] = 1'b1;
    repeat (12) tick();
  endtask

  task automatic test_random();
    int dur[NK];
    int errs = 0;
    for (int i = 0; i < NK; i++) dur[i] = 0;
    for (int j = 1; j <= 3000; j++) begin
      for (int i = 0; i < NK; i++) begin
        if (dur[i] == 0) begin
          key_in[i] = 1'($urandom_range(0, 1));
          dur[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : $urandom_range(8, 80);
        end else begin
          dur[i]--;
        end
      end
      tick();
      total++;
      if ({key_press, key_release, key_state} !== {exp_p, exp_r, lvl_m}) begin
        bad++;
        if (errs < 10)
          $display("FAIL random_model: cyc %0d got p=%b r=%b s=%b want p=%b r=%b s=%b",
                   j, key_press, key_release, key_state, exp_p, exp_r, lvl_m);
        errs++;
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    key_in = '1;
    model_reset();
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_auto_repeat();
    test_simultaneous();
    test_reset_mid_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_debounce_repeat.md
# key_debounce_repeat

Front-end key conditioning stage for the multi-function digital clock: it takes the seven raw, active-low push-button inputs, synchronises and debounces each independently, and produces clean single-cycle press/release pulses plus a debounced level for the mode/time/alarm/stopwatch control logic directly downstream. Keys +1 and -1 additionally auto-repeat while held, so values can be slewed without repeated presses.

## Interface
- NUM_KEYS, 7, number of key channels
- DEBOUNCE_CYC, 1_000_000, cycles a new level must stay stable before it is accepted (20 ms at 50 MHz)
- REPEAT_DLY_CYC, 25_000_000, cycles from the accepted press to the first auto-repeat pulse
- REPEAT_RATE_CYC, 5_000_000, cycles between later auto-repeat pulses
- REPEAT_MASK, 7'b0011000, per-key auto-repeat enable (keys 3 and 4)

- clk  input  1  system clock, the only clock
- rst_n  input  1  asynchronous, active-low reset
- key_in  input  NUM_KEYS  raw buttons, asynchronous, 0 = pressed
- key_press  output  NUM_KEYS  one-cycle pulse per accepted press and per auto-repeat
- key_release  output  NUM_KEYS  one-cycle pulse per accepted release
- key_state  output  NUM_KEYS  debounced level, 1 = pressed

## Operation
- Each key has a 2-flop synchroniser. Its reset value is 1 (released).
- Each key has its own FSM:
  - IDLE: stable released. A synchronised 0 moves to PRESS_CHK with the counter cleared.
  - PRESS_CHK: count cycles while the sample stays 0. A sample of 1 returns to IDLE and clears the counter. When the count reaches DEBOUNCE_CYC-1, go to HELD, pulse key_press and set key_state.
  - HELD: a sample of 1 moves to REL_CHK with the debounce counter cleared. Repeat keys run the repeat counter here (see below).
  - REL_CHK: a sample of 0 returns to HELD with no new pulse; the repeat counter is held, not cleared. When a stable 1 lasts DEBOUNCE_CYC cycles, go to IDLE, pulse key_release and clear key_state.
- Auto-repeat applies only to keys with REPEAT_MASK set, and only in HELD:
  - First repeat pulse: REPEAT_DLY_CYC cycles after the press pulse.
  - Later pulses: every REPEAT_RATE_CYC cycles.
  - Repeat pulses are driven on key_press, with no separate output.
  - The repeat counter clears on entry from PRESS_CHK.
- Channels are fully independent. Simultaneous presses on different keys produce pulses in the same cycle.
- Counter width is $clog2 of the largest of the three cycle parameters. Counters saturate; they never wrap.
- Reset:
  - Asserting rst_n at any time forces key_press, key_release and key_state to 0, all FSMs to IDLE, all counters to 0, and the synchronisers to 1.
  - A key held through reset release is treated as a new press and needs the full latency.

## Timing
- Press latency: key_in falls before edge k → key_press pulses in the cycle after edge k+1+DEBOUNCE_CYC, i.e. 2 + DEBOUNCE_CYC edges.
- Release latency is symmetric: 2 + DEBOUNCE_CYC edges after key_in rises.
- key_state changes in the same cycle as the corresponding pulse.
- Pulses last exactly one clk cycle. key_press and key_release for one key are never high together.
- Any low glitch shorter than DEBOUNCE_CYC synchronised cycles produces no output.
- All outputs are registered. No combinational path from key_in to any output.

## Structure
- Shared package clock_pkg holds:
  - key index constants KEY_DATE=0, KEY_MODE=1, KEY_SHIFT=2, KEY_INC=3, KEY_DEC=4, KEY_SW_RUN=5, KEY_SW_CLR=6
  - the FSM state encoding
- Sub-module key_channel holds one key's synchroniser, FSM and counters. It has a REPEAT_EN parameter and is instantiated NUM_KEYS times with generate.

## Test plan
Bench parameters: DEBOUNCE_CYC=8, REPEAT_DLY_CYC=40, REPEAT_RATE_CYC=10.
- Clean press: key_in[0] low for 15 cycles, then high → key_press[0] pulses once, 10 edges after the fall. key_state[0] is 1 until a key_release[0] pulse 10 edges after the rise.
- Glitch: key_in[2] low for 5 cycles → no pulses, key_state[2] stays 0.
- Bounce: key_in[1] toggles every 3 cycles 4 times, then stays low → exactly one key_press[1], 10 edges after the final fall.
- Auto-repeat: key_in[3] held low for 95 cycles → press pulse at edge 10, repeats at 50, 60, 70, 80, 90, none after release. key_in[5] held the same way → exactly one pulse.
- Simultaneous: key_in[3] and key_in[4] fall on the same edge → key_press[3] and key_press[4] high in the same cycle.
- Reset mid-hold: rst_n asserted while key 6 is in HELD → all outputs 0 immediately. rst_n released with key_in[6] still low → new key_press[6] 10 edges after release.
